// File: rtl/pic_irq_master.sv
// Wishbone initiator that services a level-triggered PIC:
// read pending, present lowest IRQ to the core, write-1-clear it.
module pic_irq_master #(
    parameter int          NUM_IRQ   = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        int_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    output logic [5:0]  vec_o,
    output logic        vec_valid_o,
    input  logic        vec_ready_i,
    output logic        bus_err_o,
    output logic [7:0]  spurious_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        SVC,
        WR,
        COOL
    } state_t;

    localparam logic [31:0] PEND_ADDR = BASE_ADDR + 32'hC;
    localparam logic [31:0] IRQ_MASK  = 32'hFFFF_FFFF >> (32 - NUM_IRQ);

    state_t      state;
    state_t      state_nx;
    logic [31:0] pend;
    logic [5:0]  low_vec;
    logic        cyc_nx;
    logic        we_nx;
    logic        vld_nx;
    logic        berr_nx;
    logic        spur_inc;

    // Lowest set bit wins, so scan from the top down.
    always_comb begin
        pend    = dat_i & IRQ_MASK;
        low_vec = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (pend[k]) low_vec = 6'(k + 1);
        end
    end

    always_comb begin
        state_nx = state;
        berr_nx  = 1'b0;
        spur_inc = 1'b0;
        unique case (state)
            IDLE: if (int_i) state_nx = RD;
            RD: begin
                if (err_i) begin
                    berr_nx  = 1'b1;
                    state_nx = COOL;
                end else if (ack_i) begin
                    if (pend == '0) begin
                        spur_inc = 1'b1;
                        state_nx = COOL;
                    end else begin
                        state_nx = SVC;
                    end
                end
            end
            SVC: if (vec_ready_i) state_nx = WR;
            WR: begin
                if (err_i) begin
                    berr_nx  = 1'b1;
                    state_nx = COOL;
                end else if (ack_i) begin
                    state_nx = COOL;
                end
            end
            COOL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        cyc_nx = (state_nx == RD) || (state_nx == WR);
        we_nx  = (state_nx == WR);
        vld_nx = (state_nx == SVC);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_o          <= 1'b0;
            stb_o          <= 1'b0;
            we_o           <= 1'b0;
            adr_o          <= '0;
            dat_o          <= '0;
            sel_o          <= '0;
            vec_o          <= '0;
            vec_valid_o    <= 1'b0;
            bus_err_o      <= 1'b0;
            spurious_cnt_o <= '0;
        end else begin
            cyc_o       <= cyc_nx;
            stb_o       <= cyc_nx;
            we_o        <= we_nx;
            vec_valid_o <= vld_nx;
            bus_err_o   <= berr_nx;
            if (spur_inc && spurious_cnt_o != 8'hFF)
                spurious_cnt_o <= spurious_cnt_o + 8'd1;
            if (state == IDLE && state_nx == RD) begin
                adr_o <= PEND_ADDR;
                sel_o <= 4'hF;
            end
            if (state == RD && state_nx == SVC)
                vec_o <= low_vec;
            // Write-1-clear exactly the bit being serviced.
            if (state == SVC && state_nx == WR) begin
                adr_o <= PEND_ADDR;
                sel_o <= 4'hF;
                dat_o <= 32'h1 << (vec_o - 6'd1);
            end
        end
    end

endmodule
